bcd_target_gen: RTL and testbench

// - Upstream stage of the decimal-to-binary game datapath: produces a pseudo-random 4-digit BCD target.
// - On request, emits digits d3..d0 plus their 14-bit binary value, replacing manual digit entry.
// - The digits drive the digit registers and HEX displays; target_bin feeds the answer compare.
// - A free-running 16-bit Galois LFSR supplies randomness; rejection sampling keeps each digit in 0..9.

---
 rtl/bcd_target_gen_pkg.sv | 31 +++
 rtl/bcd_target_gen_lfsr.sv | 29 ++
 rtl/bcd_target_gen.sv | 113 +++++++++++
 tb/tb_bcd_target_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_target_gen_pkg.sv
// Shared definitions for the BCD target generator: FSM encoding, LFSR constants
// and the BCD-to-binary weighting helper.
package bcd_target_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN_D3 = 3'd1,
    S_GEN_D2 = 3'd2,
    S_GEN_D1 = 3'd3,
    S_GEN_D0 = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam logic [13:0] W_THOU = 14'd1000;
  localparam logic [13:0] W_HUND = 14'd100;
  localparam logic [13:0] W_TEN  = 14'd10;
  localparam logic [13:0] W_ONE  = 14'd1;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Largest possible result is 9999, so 14 bits never overflow.
  function automatic logic [13:0] bcd_weight_sum(input logic [3:0] d3, input logic [3:0] d2,
                                                 input logic [3:0] d1, input logic [3:0] d0);
    return 14'(d3) * W_THOU + 14'(d2) * W_HUND + 14'(d1) * W_TEN + 14'(d0) * W_ONE;
  endfunction

endpackage

// File: rtl/bcd_target_gen_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed load.
// An all-zero load would lock the register, so the default seed is substituted.
module galois_lfsr16
  import bcd_target_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= (load_val == '0) ? SEED : load_val;
    end else begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : '0);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bcd_target_gen.sv
// Pseudo-random 4-digit BCD target generator: rejection-samples LFSR nibbles
// into digits, range-checks the weighted value, and presents it with a valid pulse.
module bcd_target_gen
  import bcd_target_gen_pkg::*;
#(
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter int unsigned MAX_VALUE = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic [13:0] target_bin,
  output logic [15:0] lfsr_q
);

  localparam logic [13:0] MAX14 = 14'(MAX_VALUE);

  state_t      r_state;
  logic        r_busy;
  logic        r_valid;
  logic [3:0]  r_s3, r_s2, r_s1, r_s0;
  logic [3:0]  r_d3, r_d2, r_d1, r_d0;
  logic [13:0] r_bin;

  logic [15:0] w_lfsr;
  logic [3:0]  w_cand;
  logic        w_ok;
  logic [13:0] w_sum;

  galois_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (w_lfsr)
  );

  assign w_cand = w_lfsr[3:0];
  assign w_ok   = (w_cand <= DIGIT_MAX);
  assign w_sum  = bcd_weight_sum(r_s3, r_s2, r_s1, r_s0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_s3    <= '0;
      r_s2    <= '0;
      r_s1    <= '0;
      r_s0    <= '0;
      r_d3    <= '0;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      r_bin   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_GEN_D3;
            r_busy  <= 1'b1;
          end
        end
        S_GEN_D3: if (w_ok) begin r_s3 <= w_cand; r_state <= S_GEN_D2; end
        S_GEN_D2: if (w_ok) begin r_s2 <= w_cand; r_state <= S_GEN_D1; end
        S_GEN_D1: if (w_ok) begin r_s1 <= w_cand; r_state <= S_GEN_D0; end
        S_GEN_D0: if (w_ok) begin r_s0 <= w_cand; r_state <= S_CHECK;  end
        S_CHECK: begin
          if (w_sum > MAX14) begin
            r_state <= S_GEN_D3;
          end else begin
            // Outputs load on the DONE transition so they coincide with valid.
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_d3    <= r_s3;
            r_d2    <= r_s2;
            r_d1    <= r_s1;
            r_d0    <= r_s0;
            r_bin   <= w_sum;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign valid      = r_valid;
  assign d3         = r_d3;
  assign d2         = r_d2;
  assign d1         = r_d1;
  assign d0         = r_d0;
  assign target_bin = r_bin;
  assign lfsr_q     = w_lfsr;

endmodule

// File: tb/tb_bcd_target_gen.sv
// Self-checking bench for bcd_target_gen (MAX_VALUE=1500): vector table for
// reset/seed behaviour, then a scoreboard fed by a reference generation model.
module tb_bcd_target_gen;

  localparam int unsigned MAXV = 1500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        busy, valid;
  logic [3:0]  d3, d2, d1, d0;
  logic [13:0] target_bin;
  logic [15:0] lfsr_q;

  always #5 clk = ~clk;

  bcd_target_gen #(.MAX_VALUE(MAXV)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .busy       (busy),
    .valid      (valid),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .target_bin (target_bin),
    .lfsr_q     (lfsr_q)
  );

  typedef struct {
    int unsigned c0;
    int unsigned done;
    logic [15:0] digs;
    logic [13:0] bin;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        sl;
    logic [15:0] sin;
    logic [15:0] exp_lfsr;
  } vec_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [15:0] m;
  logic [15:0] prev_digs = '0;
  logic [13:0] prev_bin = '0;
  logic        exp_busy, exp_valid;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR, tracked independently of the DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset)          m <= 16'hACE1;
    else if (seed_load) m <= (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
    else                m <= step(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Walks the generation algorithm from the LFSR value seen in the first GEN_D3 cycle.
  task automatic gen_model(input logic [15:0] v0, output logic [15:0] digs, output logic [13:0] bin,
                           output int unsigned npre, output int unsigned d1off);
    logic [15:0] v;
    logic [3:0]  dd[4];
    int unsigned k, val;
    bit          first;
    v = v0; npre = 0; d1off = 0; digs = '0; bin = '0; first = 1'b1;
    for (int att = 0; att < 10000; att++) begin
      k = 0;
      while (k < 4) begin
        if (v[3:0] <= 4'd9) begin
          dd[k] = v[3:0];
          k++;
          if (first && k == 2) d1off = npre + 1;
        end
        v = step(v);
        npre++;
      end
      val = dd[0] * 1000 + dd[1] * 100 + dd[2] * 10 + dd[3];
      v = step(v);
      npre++;
      first = 1'b0;
      if (val <= MAXV) begin
        digs = {dd[0], dd[1], dd[2], dd[3]};
        bin  = 14'(val);
        break;
      end
    end
  endtask

  task automatic push(input int unsigned c0, output int unsigned d1off);
    exp_t        e;
    int unsigned npre;
    gen_model(m, e.digs, e.bin, npre, d1off);
    e.c0   = c0;
    e.done = c0 + npre;
    sb.push_back(e);
  endtask

  task automatic do_req(output int unsigned d1off);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    push(cyc, d1off);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("lfsr_q", lfsr_q, m);
      exp_busy  = (sb.size() > 0) && (cyc >= sb[0].c0);
      exp_valid = (sb.size() > 0) && (cyc == sb[0].done);
      chk("busy", busy, exp_busy);
      chk("valid", valid, exp_valid);
      if (exp_valid) begin
        chk("digits", {d3, d2, d1, d0}, sb[0].digs);
        chk("target_bin", target_bin, sb[0].bin);
        chk("bin_sum", target_bin, d3 * 1000 + d2 * 100 + d1 * 10 + d0);
        chk("bin_range", target_bin > MAXV, 0);
        chk("d3_range", d3 > 4'd1, 0);
        prev_digs = {d3, d2, d1, d0};
        prev_bin  = target_bin;
        void'(sb.pop_front());
      end else begin
        chk("hold", {d3, d2, d1, d0, 2'b00, target_bin}, {prev_digs, 2'b00, prev_bin});
      end
    end
  end

  initial begin
    vec_t        vt[8];
    int unsigned d1off, dn;

    vt[0] = '{1'b1, 1'b0, 16'h0000, 16'hACE1};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'hE270};
    vt[2] = '{1'b0, 1'b0, 16'h0000, 16'h7138};
    vt[3] = '{1'b0, 1'b1, 16'h0000, 16'hACE1};
    vt[4] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 16'h091A};
    vt[6] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF};
    vt[7] = '{1'b0, 1'b0, 16'h0000, 16'hCBFF};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset     = vt[i].rst;
      seed_load = vt[i].sl;
      seed_in   = vt[i].sin;
      @(posedge clk);
      #1;
      chk("tbl_lfsr", lfsr_q, vt[i].exp_lfsr);
      chk("tbl_busy", busy, 0);
      chk("tbl_valid", valid, 0);
      chk("tbl_out", {d3, d2, d1, d0, 2'b00, target_bin}, 32'h0);
    end
    @(negedge clk);
    seed_load = 1'b0;
    mon_en    = 1'b1;

    // First request: busy must be up in the cycle after req is sampled.
    do_req(d1off);
    chk("busy_rise", busy, 1);
    wait_idle();

    // req pulsed while busy must not produce a second target.
    do_req(d1off);
    repeat (2) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // req held high: a new generation starts on the IDLE cycle after DONE.
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    push(cyc, d1off);
    dn = sb[0].done;
    while (cyc < dn + 1) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    push(cyc, d1off);
    @(negedge clk);
    req = 1'b0;
    wait_idle();

    // Reset during GEN_D1 aborts without a valid pulse.
    do_req(d1off);
    dn = sb[0].c0 + d1off;
    while (cyc < dn) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    prev_digs = '0;
    prev_bin  = '0;
    chk("rst_lfsr", lfsr_q, 16'hACE1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_out", {d3, d2, d1, d0, 2'b00, target_bin}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      if (i % 50 == 7) begin
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = (i % 100 == 7) ? 16'h0000 : 16'($urandom);
        @(negedge clk);
        seed_load = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(d1off);
      if (i % 97 == 3) begin
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
